// File: rtl/multicycle_control.sv
// Multicycle controller FSM for an RV32I subset (R, I-ALU, LW, SW, BEQ).
// Memory accesses use a req/ack handshake guarded by a timeout watchdog.
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic [3:0]  state_dbg
);

  // Handshake: mem_req is held high for the whole memory state; the access
  // completes on the first rising CLK edge that samples mem_ack=1 with
  // mem_req=1. mem_ack seen in any other state is ignored.

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_ERROR    = 4'd15
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, next_state;
  logic [CW-1:0]   tmo_cnt;
  logic [4:0]      opcode;
  logic            in_mem;
  logic            tmo_hit;
  logic            unused_instr;

  assign opcode       = instruction[6:2];
  assign unused_instr = ^instruction[31:7];
  assign in_mem       = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Last allowed wait cycle with no ack: leave for ERROR at this edge.
  assign tmo_hit      = in_mem && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));
  assign state_dbg    = state;

  always_comb begin
    next_state = state;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH:  if (mem_ack) next_state = S_DECODE;
                else if (tmo_hit) next_state = S_ERROR;
      S_DECODE: begin
        if (instruction[1:0] != 2'b11) next_state = S_ERROR;
        else begin
          case (opcode)
            5'b01100:         next_state = S_EXEC_R;
            5'b00100:         next_state = S_EXEC_I;
            5'b00000,
            5'b01000:         next_state = S_MEM_ADDR;
            5'b11000:         next_state = S_BRANCH;
            default:          next_state = S_ERROR;
          endcase
        end
      end
      S_EXEC_R:   next_state = S_WB_ALU;
      S_EXEC_I:   next_state = S_WB_ALU;
      S_WB_ALU:   next_state = S_FETCH;
      S_MEM_ADDR: next_state = (opcode == 5'b00000) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ack) next_state = S_WB_MEM;
                  else if (tmo_hit) next_state = S_ERROR;
      S_MEM_WR:   if (mem_ack) next_state = S_FETCH;
                  else if (tmo_hit) next_state = S_ERROR;
      S_WB_MEM:   next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_ERROR:    next_state = S_ERROR;
      default:    next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_START;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      err_cause <= 2'b00;
    end else begin
      state <= next_state;
      // Every entry into a memory state comes from a non-waiting cycle, so
      // clearing whenever we are not waiting restarts the count on entry.
      if (in_mem && !mem_ack && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
      else                                tmo_cnt <= '0;
      if (next_state == S_ERROR && state != S_ERROR) begin
        err       <= 1'b1;
        err_cause <= tmo_hit ? 2'b10 : 2'b01;
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        IRWrite = mem_ack;
        PCWrite = mem_ack;
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b00;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_WB_ALU: RegWrite = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle controller FSM for the RV32I subset datapath: R-format, I-format ALU, LW, SW, BEQ.
- Sequences a shared instruction/data memory, IR, PC, register file and ALU over several cycles per instruction.
- Talks to memory over a req/ack handshake with a timeout watchdog.
- Opcode decode is instruction[6:2]. ALUOp encoding is shared with the rest of the datapath: 00 R, 11 I, 10 add, 01 branch-compare.

Parameters:
- TIMEOUT, 16: maximum consecutive cycles a memory state may wait for mem_ack before the controller enters ERROR (≥1).

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- instruction  in  32  current IR contents
- Zero  in  1  ALU zero flag
- mem_ack  in  1  memory completion, sampled at CLK edge while mem_req=1
- mem_req  out  1  memory access request
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR from memory data
- PCWrite  out  1  load PC
- PCSrc  out  1  PC source: 0=ALU result, 1=ALUOut
- ALUSrcA  out  2  00=PC, 01=rs1 reg, 10=oldPC
- ALUSrcB  out  2  00=rs2 reg, 01=const 4, 10=immediate
- ALUOp  out  2  00 R, 11 I, 10 add, 01 branch
- MemtoReg  out  1  writeback source: 1=MDR, 0=ALUOut
- RegWrite  out  1  register file write
- err  out  1  sticky error flag
- err_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- States and encoding: START=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, ERROR=15.
- RESET (async) forces START, clears err, err_cause and the timeout counter.
- In START every output is 0; state_dbg=0. START always goes to FETCH on the next edge.
- Unless listed for a state, every control output is 0.
- FETCH: mem_req=MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=10, PCSrc=0, IRWrite=PCWrite=mem_ack (combinational). Goes to DECODE on an edge with mem_ack=1.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=10 (branch target into ALUOut). Next state:
  - instruction[1:0]≠11 → ERROR, cause 01
  - opcode 01100 → EXEC_R
  - opcode 00100 → EXEC_I
  - opcode 00000 or 01000 → MEM_ADDR
  - opcode 11000 → BRANCH
  - any other opcode → ERROR, cause 01
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=00. Goes to WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Goes to WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0. Goes to FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=10. Goes to MEM_RD if opcode 00000, else MEM_WR.
- MEM_RD: mem_req=MemRead=IorD=1. Goes to WB_MEM on mem_ack.
- MEM_WR: mem_req=MemWrite=IorD=1. Goes to FETCH on mem_ack.
- WB_MEM: RegWrite=MemtoReg=1. Goes to FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero. Goes to FETCH.
- ERROR: all controls 0, err=1, err_cause held. Stays in ERROR until RESET.
- Latency with zero-wait memory (ack in the first request cycle): R/I/SW = 4 cycles, LW = 5, BEQ = 3. Each wait cycle adds 1.
- Timeout counter:
  - Width clog2(TIMEOUT+1). Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while mem_ack=0.
  - Ack sampled high within the first TIMEOUT cycles of the state → normal transition.
  - Ack low for TIMEOUT consecutive cycles → ERROR at that edge, cause 10; mem_req drops the cycle after.
- mem_ack outside memory states is ignored.
- RESET mid-access drops mem_req immediately (asynchronous); no write strobe is left asserted.
- instruction must be stable from DECODE through completion; the controller samples opcode combinationally in DECODE and MEM_ADDR only.

Test Plan:
- R-type 0x002081B3 with mem_ack tied 1 → state sequence 1,2,3,8,1; RegWrite=1 for exactly one cycle in WB_ALU; ALUOp=00 in EXEC_R.
- LW 0x0040A183 with ack delayed 3 cycles in MEM_RD → MemRead/IorD/mem_req high for 4 cycles; WB_MEM has MemtoReg=RegWrite=1; total 8 cycles.
- BEQ 0x00208463, Zero=1 then rerun with Zero=0 → PCWrite=1, PCSrc=1 in BRANCH for the first run; PCWrite=0 for the second; each run is 3 cycles.
- Opcode 1101111 (JAL, unsupported) → ERROR after DECODE, err=1, err_cause=01, no RegWrite/MemWrite ever; persists until RESET.
- SW with mem_ack held 0, TIMEOUT=16 → MEM_WR for 16 cycles then ERROR, err_cause=10, mem_req low thereafter; an ack arriving on cycle 16 instead completes normally to FETCH.
- RESET pulsed asynchronously mid-FETCH wait → all outputs 0 immediately, state_dbg=0; FETCH resumes one cycle after release.
